// File: rtl/com_uart_tx.sv
// com_uart_tx: buffers COM bytes from the CPU in a small FIFO and serialises
// them as UART frames (8N1, idle-high line, LSB first).
// Build option: define COM_UART_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (8E1 frames).
module com_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_in,
    input  logic       end_flag,
    output logic       tx,
    output logic       busy,
    output logic       full,
    output logic       overflow,
    output logic       done
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LEN_W = PTR_W + 1;
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef COM_UART_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    state_t           state;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LEN_W-1:0] count;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             end_seen;
`ifdef COM_UART_PARITY_EN
    logic             parity_bit;
`endif

    logic push;
    logic pop;
    logic bit_end;

    // Full is judged on the pre-edge count, so a same-cycle pop never frees room.
    assign full    = (count == LEN_W'(FIFO_DEPTH));
    assign push    = byte_valid & ~full;
    assign pop     = (state == IDLE) & (count != '0);
    assign bit_end = (bit_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign busy    = (state != IDLE) | (count != '0);
    assign done    = end_seen & (count == '0) & (state == IDLE);

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= byte_in;
        end
    end

    // FIFO pointers, occupancy, sticky overflow and end-of-program tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            end_seen <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + LEN_W'(1);
                2'b01:   count <= count - LEN_W'(1);
                default: count <= count;
            endcase
            if (byte_valid && full) begin
                overflow <= 1'b1;
            end
            if (end_flag) begin
                end_seen <= 1'b1;
            end
        end
    end

    // Frame serialiser: each state holds its line level for CLKS_PER_BIT cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
`ifdef COM_UART_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift   <= mem[rd_ptr];
`ifdef COM_UART_PARITY_EN
                        parity_bit <= ^mem[rd_ptr];
`endif
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        tx      <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        tx      <= shift[0];
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef COM_UART_PARITY_EN
                            tx    <= parity_bit;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            tx      <= shift[1];
                            shift   <= {1'b0, shift[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
`ifdef COM_UART_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        tx      <= 1'b1;
                        state   <= STOP;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    tx <= 1'b1;
                    if (bit_end) begin
                        bit_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_com_uart_tx.sv
// tb_com_uart_tx: directed plus random stimulus for com_uart_tx, compared every
// cycle against a queue-based model that predicts the line from frame arithmetic.
module tb_com_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef COM_UART_PARITY_EN
    localparam int FRAME = 11 * CPB;
`else
    localparam int FRAME = 10 * CPB;
`endif

    logic       clk;
    logic       reset;
    logic       byte_valid;
    logic [7:0] byte_in;
    logic       end_flag;
    logic       tx;
    logic       busy;
    logic       full;
    logic       overflow;
    logic       done;

    int checks;
    int errors;

    // Reference model state
    logic [7:0] m_q[$];
    bit         m_active;
    int         m_start;
    logic [7:0] m_cur;
    bit         m_ovf;
    bit         m_end;
    int         cyc;
    bit         seen_full;

    com_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .byte_valid(byte_valid),
        .byte_in   (byte_in),
        .end_flag  (end_flag),
        .tx        (tx),
        .busy      (busy),
        .full      (full),
        .overflow  (overflow),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Line level for slot j of a frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
`ifdef COM_UART_PARITY_EN
        if (j == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s cyc %0d observed %0b expected %0b", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_active = 0;
        m_start  = 0;
        m_ovf    = 0;
        m_end    = 0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge(input logic v, input logic [7:0] d, input logic ef);
        bit idle_pre;
        bit full_pre;
        cyc++;
        idle_pre = !m_active || ((cyc - m_start) > FRAME);
        full_pre = (m_q.size() == DEPTH);
        if (idle_pre && m_q.size() != 0) begin
            m_cur    = m_q.pop_front();
            m_start  = cyc;
            m_active = 1;
        end
        if (v) begin
            if (full_pre) m_ovf = 1;
            else m_q.push_back(d);
        end
        if (ef) m_end = 1;
    endtask

    task automatic check_outputs();
        bit   live;
        logic exp_tx;
        live   = m_active && ((cyc - m_start) < FRAME);
        exp_tx = live ? frame_bit(m_cur, (cyc - m_start) / CPB) : 1'b1;
        chk("tx", tx, exp_tx);
        chk("busy", busy, live || (m_q.size() != 0));
        chk("full", full, m_q.size() == DEPTH);
        chk("overflow", overflow, m_ovf);
        chk("done", done, m_end && (m_q.size() == 0) && !live);
        if (full) seen_full = 1;
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic ef);
        byte_valid = v;
        byte_in    = d;
        end_flag   = ef;
        @(posedge clk);
        model_edge(v, d, ef);
        #1;
        byte_valid = 1'b0;
        end_flag   = 1'b0;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        clk        = 1'b0;
        reset      = 1'b1;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        end_flag   = 1'b0;
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        seen_full  = 0;
        model_reset();

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        reset = 1'b0;

        // Single byte 0xA5
        step(1'b1, 8'hA5, 1'b0);
        idle(FRAME + 5);

        // Burst of three
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        step(1'b1, 8'h03, 1'b0);
        idle(3 * (FRAME + 1) + 5);
        chk("burst_no_full", seen_full, 1'b0);

        // Overflow: six consecutive strobes into a depth-4 FIFO
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
        chk("ovf_full_seen", seen_full, 1'b1);
        idle(5 * (FRAME + 1) + 5);
        chk("ovf_sticky", overflow, 1'b1);

        // Completion with two bytes pending, then a late byte
        step(1'b1, 8'h3C, 1'b0);
        step(1'b1, 8'hC3, 1'b1);
        idle(2 * (FRAME + 1) + 5);
        chk("done_after_drain", done, 1'b1);
        step(1'b1, 8'h55, 1'b0);
        chk("done_drop", done, 1'b0);
        idle(FRAME + 5);

        // Asynchronous reset during data bit 3
        step(1'b1, 8'hF0, 1'b0);
        step(1'b1, 8'h0F, 1'b0);
        idle(4 * CPB + 1);
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(FRAME + 5);

        // Random traffic, including bursts that overflow
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 15) == 0) || (i % 300 < 6),
                 8'($urandom_range(0, 255)),
                 $urandom_range(0, 299) == 0);
        end
        idle(DEPTH * (FRAME + 1) + 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
